// File: rtl/proc_pkg.sv
// Shared definitions for the RV64 fetch path: opcode constants, the NOP word,
// the fetch state encoding and the registered opcode-class bundle.
package proc_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_jump;
    logic is_jal;
  } instr_class_t;

  localparam instr_class_t CLASS_NONE = '0;

  function automatic logic [63:0] word_align(input logic [63:0] addr);
    return addr & ~64'h3;
  endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode classifier: maps instr[6:0] onto one-hot class flags
// (all zero for opcodes outside the load/store/branch/jump groups).
module instr_class_decode (
  input  logic [6:0] opcode,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump,
  output logic       is_jal
);

  import proc_pkg::*;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    is_jal    = 1'b0;
    case (opcode)
      OPC_LOAD:   is_load   = 1'b1;
      OPC_STORE:  is_store  = 1'b1;
      OPC_BRANCH: is_branch = 1'b1;
      OPC_JALR:   is_jump   = 1'b1;
      OPC_JAL:    is_jal    = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Multicycle fetch stage: owns the PC, issues one memory request per
// instruction and holds the captured word plus its class flags for decode.
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_1000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic [31:0] instr,
  output logic [63:0] pc,
  output logic        instr_valid,
  output logic        isLoad,
  output logic        isStore,
  output logic        isBranch,
  output logic        isJump,
  output logic        isJal,
  output logic        misalign_err
);

  import proc_pkg::*;

  fetch_state_e state_q, state_d;
  logic [63:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  instr_class_t class_q, class_d;
  logic         instr_valid_q, instr_valid_d;
  logic         misalign_q, misalign_d;
  logic         kill_q, kill_d;

  logic [63:0]  target;
  instr_class_t dec_class;
  logic         dec_is_load;
  logic         dec_is_store;
  logic         dec_is_branch;
  logic         dec_is_jump;
  logic         dec_is_jal;

  instr_class_decode u_class_decode (
    .opcode    (imem_rdata[6:0]),
    .is_load   (dec_is_load),
    .is_store  (dec_is_store),
    .is_branch (dec_is_branch),
    .is_jump   (dec_is_jump),
    .is_jal    (dec_is_jal)
  );

  assign dec_class = '{is_load:   dec_is_load,
                       is_store:  dec_is_store,
                       is_branch: dec_is_branch,
                       is_jump:   dec_is_jump,
                       is_jal:    dec_is_jal};

  assign target = word_align(redirect_pc);

  // Request is gated by reset so nothing is presented during the reset cycle.
  assign imem_req  = (state_q == S_FETCH) && !reset;
  assign imem_addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    class_d    = class_q;
    kill_d     = kill_q;
    misalign_d = redirect && (redirect_pc[1:0] != 2'b00);

    case (state_q)
      S_FETCH: begin
        if (redirect) begin
          pc_d = target;
        end
        if (imem_gnt) begin
          state_d = S_WAIT;
          kill_d  = redirect;
        end
      end

      // A redirect arriving together with rvalid still squashes that word,
      // since the data belongs to the abandoned PC.
      S_WAIT: begin
        if (redirect) begin
          pc_d   = target;
          kill_d = 1'b1;
        end
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = S_FETCH;
          end else begin
            instr_d = imem_rdata;
            class_d = dec_class;
            state_d = S_HOLD;
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_FETCH;
        end else if (!stall) begin
          pc_d    = pc_q + 64'd4;
          state_d = S_FETCH;
        end
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase

    instr_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      instr_q       <= INSTR_NOP;
      class_q       <= CLASS_NONE;
      instr_valid_q <= 1'b0;
      misalign_q    <= 1'b0;
      kill_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      class_q       <= class_d;
      instr_valid_q <= instr_valid_d;
      misalign_q    <= misalign_d;
      kill_q        <= kill_d;
    end
  end

  assign instr        = instr_q;
  assign pc           = pc_q;
  assign instr_valid  = instr_valid_q;
  assign isLoad       = class_q.is_load;
  assign isStore      = class_q.is_store;
  assign isBranch     = class_q.is_branch;
  assign isJump       = class_q.is_jump;
  assign isJal        = class_q.is_jal;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: the bench plays instruction memory
// and compares every output each cycle against a transaction-level model.
module tb_instr_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_0000_1000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [31:0] instr;
  logic [63:0] pc;
  logic        instr_valid;
  logic        isLoad;
  logic        isStore;
  logic        isBranch;
  logic        isJump;
  logic        isJal;
  logic        misalign_err;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr        (instr),
    .pc           (pc),
    .instr_valid  (instr_valid),
    .isLoad       (isLoad),
    .isStore      (isStore),
    .isBranch     (isBranch),
    .isJump       (isJump),
    .isJal        (isJal),
    .misalign_err (misalign_err)
  );

  int compare_count  = 0;
  int mismatch_count = 0;

  // Transaction view of the fetch stage: exactly one of "asking memory",
  // "a response is owed" or "an instruction is held" is true at a time.
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  bit          m_asking;
  bit          m_owed;
  bit          m_discard;
  bit          m_holding;
  bit          m_misalign;

  // Per-mille probabilities steering the random stimulus.
  int p_gnt, p_rvalid, p_stray, p_stall, p_redirect, p_reset, p_high_target;

  function automatic logic [4:0] expectedClass(input logic [31:0] word);
    case (word[6:0])
      7'h03:   return 5'b10000;
      7'h23:   return 5'b01000;
      7'h63:   return 5'b00100;
      7'h67:   return 5'b00010;
      7'h6F:   return 5'b00001;
      default: return 5'b00000;
    endcase
  endfunction

  function automatic logic [31:0] randomWord();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 6))
      0: w[6:0] = 7'h03;
      1: w[6:0] = 7'h23;
      2: w[6:0] = 7'h63;
      3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h6F;
      5: w[6:0] = 7'h13;
      default: ;
    endcase
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compare_count++;
    if (observed !== expected) begin
      mismatch_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_pc       = RESET_PC;
    m_instr    = NOP_WORD;
    m_asking   = 1'b1;
    m_owed     = 1'b0;
    m_discard  = 1'b0;
    m_holding  = 1'b0;
    m_misalign = 1'b0;
  endtask

  task automatic applyStimulus();
    reset    = ($urandom_range(0, 999) < p_reset);
    imem_gnt = m_asking && ($urandom_range(0, 999) < p_gnt);
    if (m_owed) imem_rvalid = ($urandom_range(0, 999) < p_rvalid);
    else        imem_rvalid = ($urandom_range(0, 999) < p_stray);
    imem_rdata = randomWord();
    stall      = ($urandom_range(0, 999) < p_stall);
    redirect   = ($urandom_range(0, 999) < p_redirect);
    if ($urandom_range(0, 999) < p_high_target)
      redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
    else
      redirect_pc = {$urandom(), $urandom()};
  endtask

  task automatic checkAll();
    checkOutput("imem_req",     64'(imem_req),     64'(m_asking && !reset));
    checkOutput("imem_addr",    imem_addr,         m_pc);
    checkOutput("pc",           pc,                m_pc);
    checkOutput("instr",        64'(instr),        64'(m_instr));
    checkOutput("instr_valid",  64'(instr_valid),  64'(m_holding));
    checkOutput("class_flags",  64'({isLoad, isStore, isBranch, isJump, isJal}), 64'(expectedClass(m_instr)));
    checkOutput("misalign_err", 64'(misalign_err), 64'(m_misalign));
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic modelStep();
    logic [63:0] dest;
    bit          bad_target;
    if (reset) begin
      modelReset();
      return;
    end
    dest       = redirect_pc - 64'(redirect_pc[1:0]);
    bad_target = redirect && (redirect_pc[1:0] != 2'b00);
    if (m_asking) begin
      if (redirect) m_pc = dest;
      if (imem_gnt) begin
        m_asking  = 1'b0;
        m_owed    = 1'b1;
        m_discard = redirect;
      end
    end else if (m_owed) begin
      if (redirect) begin
        m_pc      = dest;
        m_discard = 1'b1;
      end
      if (imem_rvalid) begin
        m_owed = 1'b0;
        if (m_discard) begin
          m_discard = 1'b0;
          m_asking  = 1'b1;
        end else begin
          m_instr   = imem_rdata;
          m_holding = 1'b1;
        end
      end
    end else if (m_holding) begin
      if (redirect || !stall) begin
        m_pc      = redirect ? dest : m_pc + 64'd4;
        m_holding = 1'b0;
        m_asking  = 1'b1;
      end
    end
    m_misalign = bad_target;
  endtask

  task automatic setKnobs(input int gnt, input int rv, input int stray, input int stl,
                          input int redir, input int rst, input int high);
    p_gnt = gnt; p_rvalid = rv; p_stray = stray; p_stall = stl;
    p_redirect = redir; p_reset = rst; p_high_target = high;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus();
      #1;
      checkAll();
      modelStep();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset       = 1'b1;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    $display("[TB] zero-wait memory, no stall");
    setKnobs(1000, 1000, 0, 0, 0, 0, 0);
    runCycles(40);

    $display("[TB] stall-heavy with slow grants");
    setKnobs(300, 400, 0, 800, 0, 0, 0);
    runCycles(300);

    $display("[TB] redirects, stray rvalid, misaligned targets");
    setKnobs(500, 500, 150, 400, 120, 0, 0);
    runCycles(800);

    $display("[TB] wrap near top of address space");
    setKnobs(900, 900, 50, 100, 40, 0, 600);
    runCycles(600);

    $display("[TB] full mix including resets");
    setKnobs(500, 500, 200, 400, 80, 20, 150);
    runCycles(2500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
    $finish;
  end

endmodule
